// File: rtl/shifter_serial.sv
// Serial bit-step shifter: rotate right, shift left, arithmetic right, logical right.
// Optional macro SHFT_DUAL_STEP_EN applies up to two bit-steps per SHIFT cycle.
module shifter_serial (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] In,
    input  logic [3:0]  Cnt,
    input  logic [1:0]  Op,
    output logic [15:0] Out,
    output logic        busy,
    output logic        done
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    logic [1:0]  state_q, state_d;
    logic [15:0] work_q, work_d;
    logic [3:0]  rem_q, rem_d;
    logic [1:0]  op_q, op_d;
    logic [15:0] out_q, out_d;

    function automatic logic [15:0] step1(input logic [15:0] v, input logic [1:0] op);
        logic signed [15:0] sv;
        sv = v;
        case (op)
            2'b00:   step1 = {v[0], v[15:1]};
            2'b01:   step1 = {v[14:0], 1'b0};
            2'b10:   step1 = $unsigned(sv >>> 1);
            default: step1 = {1'b0, v[15:1]};
        endcase
    endfunction

    always_comb begin
        state_d = state_q;
        work_d  = work_q;
        rem_d   = rem_q;
        op_d    = op_q;
        out_d   = out_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    work_d = In;
                    op_d   = Op;
                    rem_d  = Cnt;
                    if (Cnt == 4'd0) begin
                        state_d = ST_DONE;
                        out_d   = In;
                    end else begin
                        state_d = ST_SHIFT;
                    end
                end
            end
            ST_SHIFT: begin
`ifdef SHFT_DUAL_STEP_EN
                if (rem_q >= 4'd2) begin
                    work_d = step1(step1(work_q, op_q), op_q);
                    rem_d  = rem_q - 4'd2;
                end else begin
                    work_d = step1(work_q, op_q);
                    rem_d  = rem_q - 4'd1;
                end
                if (rem_q <= 4'd2) begin
                    state_d = ST_DONE;
                    out_d   = work_d;
                end
`else
                work_d = step1(work_q, op_q);
                rem_d  = rem_q - 4'd1;
                if (rem_q == 4'd1) begin
                    state_d = ST_DONE;
                    out_d   = work_d;
                end
`endif
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Reset clears the datapath too so Out reads zero after any reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            work_q  <= 16'h0000;
            rem_q   <= 4'd0;
            op_q    <= 2'b00;
            out_q   <= 16'h0000;
        end else begin
            state_q <= state_d;
            work_q  <= work_d;
            rem_q   <= rem_d;
            op_q    <= op_d;
            out_q   <= out_d;
        end
    end

    assign Out  = out_q;
    assign busy = (state_q != ST_IDLE);
    assign done = (state_q == ST_DONE);

endmodule

// File: tb/tb_shifter_serial.sv
// Bench for shifter_serial: directed vectors plus random ops against an arithmetic model.
module tb_shifter_serial;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [15:0] In = 16'h0;
    logic [3:0]  Cnt = 4'h0;
    logic [1:0]  Op = 2'b00;
    logic [15:0] Out;
    logic        busy;
    logic        done;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    shifter_serial dut (
        .clk(clk), .rst(rst), .start(start), .In(In), .Cnt(Cnt), .Op(Op),
        .Out(Out), .busy(busy), .done(done)
    );

    function automatic logic [15:0] model_result(input logic [15:0] v, input int n, input logic [1:0] op);
        logic [31:0]        d;
        logic signed [15:0] s;
        logic [15:0]        r;
        s = v;
        case (op)
            2'b00: begin d = {v, v} >> n; r = d[15:0]; end
            2'b01: r = v << n;
            2'b10: r = $unsigned(s >>> n);
            default: r = v >> n;
        endcase
        return r;
    endfunction

    function automatic int model_lat(input int n);
`ifdef SHFT_DUAL_STEP_EN
        return (n + 1) / 2 + 1;
`else
        return n + 1;
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issues one op starting in the current cycle and waits (bounded) for done.
    task automatic do_op(input logic [15:0] i, input logic [3:0] c, input logic [1:0] o,
                         output logic [15:0] res, output int lat,
                         output int early_chg, output int busy_gaps);
        logic [15:0] prev;
        prev = Out;
        early_chg = 0;
        busy_gaps = 0;
        start = 1'b1; In = i; Cnt = c; Op = o;
        tick();
        start = 1'b0;
        In = 16'($urandom); Cnt = 4'($urandom); Op = 2'($urandom);
        lat = 1;
        while (!done && lat < 40) begin
            if (Out !== prev) early_chg++;
            if (busy !== 1'b1) busy_gaps++;
            tick();
            lat++;
        end
        res = Out;
    endtask

    task automatic test_reset();
        logic [15:0] res;
        int lat, ec, bg;
        rst = 1'b1;
        repeat (3) tick();
        total++; if (Out !== 16'h0000) begin bad++; $display("FAIL reset_out: got %h want 0000", Out); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", done); end
        rst = 1'b0;
        do_op(16'h8001, 4'd4, 2'b10, res, lat, ec, bg);
        total++; if (res !== 16'hF800) begin bad++; $display("FAIL first_op_out: got %h want f800", res); end
        total++; if (lat !== model_lat(4)) begin bad++; $display("FAIL first_op_lat: got %0d want %0d", lat, model_lat(4)); end
        tick();
    endtask

    task automatic test_directed();
        logic [15:0] vin [5] = '{16'h0001, 16'h1234, 16'h8000, 16'h0001, 16'h0003};
        logic [3:0]  vc  [5] = '{4'd1, 4'd0, 4'd15, 4'd3, 4'd2};
        logic [1:0]  vo  [5] = '{2'b00, 2'b01, 2'b10, 2'b00, 2'b01};
        logic [15:0] vexp[5] = '{16'h8000, 16'h1234, 16'hFFFF, 16'h2000, 16'h000C};
        logic [15:0] res;
        int lat, ec, bg;
        for (int k = 0; k < 5; k++) begin
            do_op(vin[k], vc[k], vo[k], res, lat, ec, bg);
            total++; if (res !== vexp[k]) begin bad++; $display("FAIL dir%0d_out: got %h want %h", k, res, vexp[k]); end
            total++; if (lat !== model_lat(int'(vc[k]))) begin bad++; $display("FAIL dir%0d_lat: got %0d want %0d", k, lat, model_lat(int'(vc[k]))); end
            total++; if (ec !== 0 || bg !== 0) begin bad++; $display("FAIL dir%0d_hold: got chg=%0d gaps=%0d want 0 0", k, ec, bg); end
            total++; if (busy !== 1'b1) begin bad++; $display("FAIL dir%0d_busy_done: got %b want 1", k, busy); end
            tick();
            total++; if (done !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL dir%0d_pulse: got done=%b busy=%b want 0 0", k, done, busy); end
        end
    endtask

    task automatic test_ignore_busy();
        int first, pulses;
        logic [15:0] res;
        first = -1; pulses = 0; res = 16'h0;
        start = 1'b1; In = 16'h8000; Cnt = 4'd15; Op = 2'b11;
        tick();
        for (int cyc = 1; cyc <= 25; cyc++) begin
            if (cyc == 5) begin
                start = 1'b1; In = 16'hFFFF; Cnt = 4'd1; Op = 2'b00;
            end else begin
                start = 1'b0;
            end
            if (done) begin
                pulses++;
                if (first < 0) begin first = cyc; res = Out; end
            end
            tick();
        end
        total++; if (first !== model_lat(15)) begin bad++; $display("FAIL ign_lat: got %0d want %0d", first, model_lat(15)); end
        total++; if (res !== 16'h0001) begin bad++; $display("FAIL ign_out: got %h want 0001", res); end
        total++; if (pulses !== 1) begin bad++; $display("FAIL ign_pulses: got %0d want 1", pulses); end
    endtask

    task automatic test_reset_mid();
        logic [15:0] res;
        int lat, ec, bg, pulses;
        start = 1'b1; In = 16'h00FF; Cnt = 4'd8; Op = 2'b01;
        tick();
        start = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        total++; if (busy !== 1'b0 || done !== 1'b0) begin bad++; $display("FAIL rmid_ctrl: got busy=%b done=%b want 0 0", busy, done); end
        total++; if (Out !== 16'h0000) begin bad++; $display("FAIL rmid_out: got %h want 0000", Out); end
        pulses = 0;
        for (int k = 0; k < 12; k++) begin
            if (done) pulses++;
            tick();
        end
        total++; if (pulses !== 0) begin bad++; $display("FAIL rmid_nodone: got %0d want 0", pulses); end
        do_op(16'h0003, 4'd2, 2'b01, res, lat, ec, bg);
        total++; if (res !== 16'h000C) begin bad++; $display("FAIL rmid_next_out: got %h want 000c", res); end
        total++; if (lat !== model_lat(2)) begin bad++; $display("FAIL rmid_next_lat: got %0d want %0d", lat, model_lat(2)); end
        tick();
    endtask

    task automatic test_back_to_back();
        logic [15:0] res;
        int lat, ec, bg;
        do_op(16'hA5C3, 4'd5, 2'b00, res, lat, ec, bg);
        total++; if (res !== model_result(16'hA5C3, 5, 2'b00)) begin bad++; $display("FAIL b2b_a_out: got %h want %h", res, model_result(16'hA5C3, 5, 2'b00)); end
        // start during the done cycle must be dropped
        start = 1'b1; In = 16'hFFFF; Cnt = 4'd7; Op = 2'b01;
        tick();
        start = 1'b0;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL b2b_ignore_done: got busy=%b want 0", busy); end
        do_op(16'h4321, 4'd6, 2'b10, res, lat, ec, bg);
        total++; if (res !== model_result(16'h4321, 6, 2'b10)) begin bad++; $display("FAIL b2b_b_out: got %h want %h", res, model_result(16'h4321, 6, 2'b10)); end
        total++; if (lat !== model_lat(6)) begin bad++; $display("FAIL b2b_b_lat: got %0d want %0d", lat, model_lat(6)); end
        tick();
    endtask

    task automatic test_random();
        logic [15:0] i, res, exp;
        logic [3:0]  c;
        logic [1:0]  o;
        int lat, ec, bg;
        for (int k = 0; k < 40; k++) begin
            repeat ($urandom_range(0, 2)) tick();
            i = 16'($urandom); c = 4'($urandom); o = 2'($urandom);
            exp = model_result(i, int'(c), o);
            do_op(i, c, o, res, lat, ec, bg);
            total++; if (res !== exp) begin bad++; $display("FAIL rnd%0d_out: in=%h cnt=%0d op=%0d got %h want %h", k, i, c, o, res, exp); end
            total++; if (lat !== model_lat(int'(c))) begin bad++; $display("FAIL rnd%0d_lat: got %0d want %0d", k, lat, model_lat(int'(c))); end
            total++; if (ec !== 0 || bg !== 0) begin bad++; $display("FAIL rnd%0d_hold: got chg=%0d gaps=%0d want 0 0", k, ec, bg); end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_ignore_busy();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
